// File: rtl/spi_slave_frame.sv
// spi_slave_frame
//   SPI slave with configurable frame length, SPI mode (CPOL/CPHA), bit order
//   and input glitch filter. All SPI pins are oversampled in the CLK domain.
//   RX data is delivered only for frames with exactly FRAME_BITS bits;
//   frames of any other length set the sticky FRAME_ERR flag instead.
//
// Ports
//   CLK        system clock (sole clock)
//   RESET      asynchronous, active-high reset
//   SPI_CS     chip select from master, active low
//   SPI_CLK    SCLK from master
//   SPI_MOSI   master-to-slave data
//   DATA_TX    word sent to master, captured when a frame starts
//   SPI_MISO   slave-to-master data
//   DATA_RX    last complete received frame
//   RX_VALID   one-CLK pulse when DATA_RX updates
//   FRAME_ERR  sticky: last frame had the wrong bit count
//   BUSY       frame in progress
module spi_slave_frame #(
    parameter int FRAME_BITS = 512,
    parameter int FILTER     = 5,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SPI_CS,
    input  logic                  SPI_CLK,
    input  logic                  SPI_MOSI,
    input  logic [FRAME_BITS-1:0] DATA_TX,
    output logic                  SPI_MISO,
    output logic [FRAME_BITS-1:0] DATA_RX,
    output logic                  RX_VALID,
    output logic                  FRAME_ERR,
    output logic                  BUSY
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] FULL  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] OVER  = CW'(FRAME_BITS + 1);
    localparam logic [CW-1:0] LASTC = CW'(FRAME_BITS - 1);
    localparam logic SCLK_IDLE = (CPOL != 0);
    // Idle levels of {MOSI, SCLK, CS}
    localparam logic [2:0] IDLE_LVL = {1'b0, SCLK_IDLE, 1'b1};

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0]            raw;
    logic [2:0]            filt;
    logic [1:0]            prev;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [FRAME_BITS-1:0] shift_tx;
    logic [FRAME_BITS-1:0] shift_rx;
    logic                  armed;

    assign raw = {SPI_MOSI, SPI_CLK, SPI_CS};

    // Per-input glitch filter: output follows the input only after FILTER
    // consecutive samples at the opposite level.
    for (genvar g = 0; g < 3; g++) begin : g_filt
        if (FILTER == 0) begin : g_bypass
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) filt[g] <= IDLE_LVL[g];
                else       filt[g] <= raw[g];
            end
        end else begin : g_count
            logic [7:0] fcnt;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    filt[g] <= IDLE_LVL[g];
                    fcnt    <= '0;
                end else if (raw[g] == filt[g]) begin
                    fcnt <= '0;
                end else if (fcnt == 8'(FILTER - 1)) begin
                    filt[g] <= raw[g];
                    fcnt    <= '0;
                end else begin
                    fcnt <= fcnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) prev <= IDLE_LVL[1:0];
        else       prev <= filt[1:0];
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, lead_e, trail_e, sample_e, shift_e;
    assign cs_fall   =  prev[0] & ~filt[0];
    assign cs_rise   = ~prev[0] &  filt[0];
    assign sclk_rise = ~prev[1] &  filt[1];
    assign sclk_fall =  prev[1] & ~filt[1];
    assign lead_e    = SCLK_IDLE ? sclk_fall : sclk_rise;
    assign trail_e   = SCLK_IDLE ? sclk_rise : sclk_fall;
    assign sample_e  = (CPHA != 0) ? trail_e : lead_e;
    assign shift_e   = (CPHA != 0) ? lead_e  : trail_e;

    // Bit position addressed by counter value c (valid for c < FRAME_BITS)
    function automatic logic [IW-1:0] bidx(input logic [CW-1:0] c);
        return IW'((LSB_FIRST != 0) ? c : LASTC - c);
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            DATA_RX   <= '0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
            SPI_MISO  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            // The filter restarts at CS=1 after reset; if the pin is still low
            // (reset mid-frame) the filter then produces a fake CS fall. Only
            // accept a fall once CS has genuinely been seen high.
            if (filt[0] && SPI_CS) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state    <= ACTIVE;
                        cnt      <= '0;
                        shift_tx <= DATA_TX;
                        shift_rx <= '0;
                        BUSY     <= 1'b1;
                        SPI_MISO <= (CPHA == 0) ? DATA_TX[bidx('0)] : 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        SPI_MISO <= 1'b0;
                        if (cnt == FULL) begin
                            DATA_RX   <= shift_rx;
                            RX_VALID  <= 1'b1;
                            FRAME_ERR <= 1'b0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end else if (sample_e) begin
                        if (cnt < FULL) begin
                            shift_rx[bidx(cnt)] <= filt[2];
                            cnt <= cnt + CW'(1);
                        end else begin
                            cnt <= OVER;
                        end
                    end else if (shift_e) begin
                        SPI_MISO <= (cnt < FULL) ? shift_tx[bidx(cnt)] : 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: two instances (mode 0 LSB-first, mode 3
// MSB-first, 16-bit frames, FILTER=5) driven by a bit-banged master.
module tb_spi_slave_frame;

    localparam int FILT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cs[2], sclk[2], mosi[2], miso[2], rxv[2], ferr[2], busy[2];
    logic [15:0] tx[2], rx[2];

    spi_slave_frame #(.FRAME_BITS(16), .FILTER(FILT), .CPOL(0), .CPHA(0), .LSB_FIRST(1)) u_m0 (
        .CLK(clk), .RESET(rst), .SPI_CS(cs[0]), .SPI_CLK(sclk[0]), .SPI_MOSI(mosi[0]),
        .DATA_TX(tx[0]), .SPI_MISO(miso[0]), .DATA_RX(rx[0]), .RX_VALID(rxv[0]),
        .FRAME_ERR(ferr[0]), .BUSY(busy[0]));

    spi_slave_frame #(.FRAME_BITS(16), .FILTER(FILT), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) u_m3 (
        .CLK(clk), .RESET(rst), .SPI_CS(cs[1]), .SPI_CLK(sclk[1]), .SPI_MOSI(mosi[1]),
        .DATA_TX(tx[1]), .SPI_MISO(miso[1]), .DATA_RX(rx[1]), .RX_VALID(rxv[1]),
        .FRAME_ERR(ferr[1]), .BUSY(busy[1]));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_rx[2];
    logic        exp_err[2], exp_busy[2];
    bit          chk_en[2];
    int          vcnt[2], exp_vcnt[2];
    logic        vprev[2];
    logic [15:0] last_miso;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Continuous compare against the model's settled expectations
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                check("rx_valid_width", 32'(vprev[i] & rxv[i]), 32'd0);
                if (chk_en[i]) begin
                    check("data_rx",   32'(rx[i]),   32'(exp_rx[i]));
                    check("frame_err", 32'(ferr[i]), 32'(exp_err[i]));
                    check("busy",      32'(busy[i]), 32'(exp_busy[i]));
                    check("rx_valid",  32'(rxv[i]),  32'd0);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rxv[i]) vcnt[i] <= vcnt[i] + 1;
            vprev[i] <= rxv[i];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int half();
        return int'($urandom_range(10, 14));
    endfunction

    // Bit position carried by the k-th serial bit (inst 0 LSB-first, inst 1 MSB-first)
    function automatic logic [3:0] pos(input int inst, input int k);
        return 4'((inst == 0) ? k : 15 - k);
    endfunction

    task automatic model_sample(input int inst, input logic b, inout int nb, inout logic [15:0] rxw);
        if (nb < 16) rxw[pos(inst, nb)] = b;
        nb++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_miso",      32'(miso[i]), 32'd0);
            check("reset_data_rx",   32'(rx[i]),   32'd0);
            check("reset_rx_valid",  32'(rxv[i]),  32'd0);
            check("reset_frame_err", 32'(ferr[i]), 32'd0);
            check("reset_busy",      32'(busy[i]), 32'd0);
            exp_rx[i]   = '0;
            exp_err[i]  = 1'b0;
            exp_busy[i] = 1'b0;
        end
        cyc(2);
        #2 rst = 1'b0;
    endtask

    // One master transaction. gpos/glen: extra SCLK pulse of glen CLKs after
    // real clock gpos. rst_at: assert RESET after that many clocks.
    task automatic frame(input int inst, input int nclk, input logic [15:0] mw, input logic [15:0] tw,
                         input int gpos, input int glen, input int rst_at);
        logic        idle_lvl;
        bit          cpha;
        int          nb;
        logic [15:0] rxw;
        bit          aborted;
        logic        b;
        logic        exp_m;
        idle_lvl = (inst == 1);
        cpha     = (inst == 1);
        nb       = 0;
        rxw      = '0;
        aborted  = 0;
        last_miso = '0;
        tx[inst] = tw;
        chk_en[inst] = 0;
        cs[inst] = 1'b0;
        cyc(12);
        tx[inst] = 16'($urandom);
        exp_busy[inst] = 1'b1;
        chk_en[inst] = 1;
        for (int k = 0; k < nclk; k++) begin
            b = (k < 16) ? mw[pos(inst, k)] : 1'($urandom);
            if (!cpha) mosi[inst] = b;
            cyc(half());
            exp_m = (aborted || nb >= 16) ? 1'b0 : tw[pos(inst, nb)];
            if (!cpha) begin
                check("miso", 32'(miso[inst]), 32'(exp_m));
                if (k < 16) last_miso[pos(inst, k)] = miso[inst];
            end
            sclk[inst] = ~idle_lvl;
            if (cpha) mosi[inst] = b;
            else if (!aborted) model_sample(inst, b, nb, rxw);
            cyc(half());
            if (cpha) begin
                check("miso", 32'(miso[inst]), 32'(exp_m));
                if (k < 16) last_miso[pos(inst, k)] = miso[inst];
            end
            sclk[inst] = idle_lvl;
            if (cpha && !aborted) model_sample(inst, b, nb, rxw);
            if (k == gpos) begin
                cyc(half());
                sclk[inst] = ~idle_lvl;
                cyc(glen);
                sclk[inst] = idle_lvl;
                if (glen >= FILT && !aborted) model_sample(inst, mosi[inst], nb, rxw);
            end
            if (k + 1 == rst_at) begin
                do_reset();
                aborted = 1;
            end
        end
        cyc(half());
        chk_en[inst] = 0;
        cs[inst] = 1'b1;
        cyc(12);
        if (!aborted) begin
            if (nb == 16) begin
                exp_rx[inst]  = rxw;
                exp_err[inst] = 1'b0;
                exp_vcnt[inst]++;
            end else begin
                exp_err[inst] = 1'b1;
            end
        end
        exp_busy[inst] = 1'b0;
        check("rx_valid_count", 32'(vcnt[inst]), 32'(exp_vcnt[inst]));
        chk_en[inst] = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int inst, n, gp, gl;
        for (int i = 0; i < 2; i++) begin
            cs[i] = 1'b1; sclk[i] = (i == 1); mosi[i] = 1'b0; tx[i] = '0;
            exp_rx[i] = '0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0;
            chk_en[i] = 0; vcnt[i] = 0; exp_vcnt[i] = 0; vprev[i] = 1'b0;
        end
        cyc(3);
        #2 rst = 1'b0;
        cyc(2);
        check("post_reset_rx", 32'(rx[0]), 32'd0);
        check("post_reset_miso", 32'(miso[0]), 32'd0);
        chk_en[0] = 1; chk_en[1] = 1;

        // Mode 0, LSB first
        frame(0, 16, 16'h1234, 16'hA5C3, -1, 0, -1);
        check("m0_rx_lit", 32'(rx[0]), 32'h1234);
        check("m0_miso_lit", 32'(last_miso), 32'hA5C3);
        check("m0_err_lit", 32'(ferr[0]), 32'd0);
        check("m0_valid_lit", 32'(vcnt[0]), 32'd1);

        // Short frame, then recovery
        frame(0, 15, 16'($urandom), 16'($urandom), -1, 0, -1);
        check("short_rx_lit", 32'(rx[0]), 32'h1234);
        check("short_err_lit", 32'(ferr[0]), 32'd1);
        frame(0, 16, 16'hBEEF, 16'($urandom), -1, 0, -1);
        check("beef_rx_lit", 32'(rx[0]), 32'hBEEF);
        check("beef_err_lit", 32'(ferr[0]), 32'd0);

        // Long frame
        frame(0, 18, 16'($urandom), 16'($urandom), -1, 0, -1);
        check("long_rx_lit", 32'(rx[0]), 32'hBEEF);
        check("long_err_lit", 32'(ferr[0]), 32'd1);

        // Mode 3, MSB first
        frame(1, 16, 16'h00FF, 16'h8001, -1, 0, -1);
        check("m3_rx_lit", 32'(rx[1]), 32'h00FF);
        check("m3_miso_lit", 32'(last_miso), 32'h8001);

        // Glitches on SCLK: 4 CLKs rejected, 7 CLKs counted as an extra bit
        frame(0, 16, 16'($urandom), 16'($urandom), 5, 4, -1);
        check("glitch4_err_lit", 32'(ferr[0]), 32'd0);
        frame(0, 16, 16'($urandom), 16'($urandom), 5, 7, -1);
        check("glitch7_err_lit", 32'(ferr[0]), 32'd1);

        // Reset after 8 bits, then a clean frame
        frame(0, 16, 16'($urandom), 16'($urandom), -1, 0, 8);
        check("rst_err_lit", 32'(ferr[0]), 32'd0);
        check("rst_rx_lit", 32'(rx[0]), 32'd0);
        frame(0, 16, 16'hC0DE, 16'($urandom), -1, 0, -1);
        check("after_rst_rx_lit", 32'(rx[0]), 32'hC0DE);

        // Randomized frames on both instances
        for (int t = 0; t < 12; t++) begin
            inst = int'($urandom_range(0, 1));
            n    = int'($urandom_range(14, 18));
            if ($urandom_range(0, 1) == 0) n = 16;
            gp   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
            gl   = ($urandom_range(0, 1) == 0) ? 3 : 8;
            frame(inst, n, 16'($urandom), 16'($urandom), gp, gl, -1);
        end

        cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
- Parametrised SPI slave, successor of the fixed 512-bit single-mode Teensy link slave.
- Configurable frame length, SPI mode (CPOL/CPHA), bit order and input filter length.
- Validates frame length: delivers RX data with a valid strobe only on complete frames; flags errored frames.
- Sits between the external MCU SPI pins and the register/data block of the FPGA, in the CLK domain.

Parameters:
- FRAME_BITS, 512, bits per frame (8..4095).
- FILTER, 5, glitch filter length in CLK cycles (0 = bypass, max 255).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 1, 1 = bit 0 first on both MOSI and MISO; 0 = MSB first.

Ports:
- CLK  in  1  system clock, sole clock.
- RESET  in  1  asynchronous, active-high reset.
- SPI_CS  in  1  chip select from master, active low.
- SPI_CLK  in  1  SCLK from master.
- SPI_MOSI  in  1  master data in.
- DATA_TX  in  FRAME_BITS  word sent to master; captured at frame start.
- SPI_MISO  out  1  slave data out.
- DATA_RX  out  FRAME_BITS  last complete received frame.
- RX_VALID  out  1  one-CLK pulse when DATA_RX updates.
- FRAME_ERR  out  1  sticky; last frame had wrong bit count.
- BUSY  out  1  frame in progress.

Behaviour:
- **Clock and reset:** one clock, CLK. RESET is asynchronous, active-high.
- **Reset values:**
  - SPI_MISO=0, DATA_RX=0, RX_VALID=0, FRAME_ERR=0, BUSY=0, state IDLE.
  - Filter outputs reset to idle levels: CS=1, SCLK=CPOL, MOSI=0. This prevents spurious edges after reset.
- **Input filter (per input):**
  - The output toggles only after FILTER consecutive CLK samples at the opposite level; any sample at the current level restarts the count.
  - FILTER=0: output is the input registered once.
- **Edge detection:** each filtered signal is registered once. An edge exists for one cycle where filtered != previous.
- **Timing constraint:** the master must hold each SCLK half-period and each CS-to-SCLK gap for at least FILTER+3 CLK cycles.
- **States:** IDLE and ACTIVE.
  - IDLE -> ACTIVE on filtered CS falling edge: bit counter=0, shift_tx<=DATA_TX, shift_rx<=0, BUSY=1.
  - ACTIVE -> IDLE on filtered CS rising edge.
  - SCLK edges in IDLE are ignored.
- **Edge roles:**
  - Leading edge = rising if CPOL=0, else falling.
  - Sample edge = leading if CPHA=0, else trailing.
  - Shift edge = the other edge.
- **MISO, CPHA=0:** first bit is driven the cycle after CS fall is detected. Subsequent bits are driven on each shift edge.
- **MISO, CPHA=1:** each bit, including the first, is driven on a leading edge.
- **Bit selection:** index = bit counter (LSB_FIRST=1) or FRAME_BITS-1-counter (LSB_FIRST=0).
- **Sampling:** on each sample edge, MOSI is written into shift_rx at the same index and the counter increments.
- **Counter saturation:** the counter saturates at FRAME_BITS+1 (overrun marker). After FRAME_BITS bits, further samples are discarded and MISO=0.
- **Frame end (CS rise):**
  - BUSY=0 and MISO=0.
  - If counter == FRAME_BITS: DATA_RX<=shift_rx, RX_VALID=1 for exactly one cycle, FRAME_ERR<=0.
  - Otherwise: DATA_RX is held, there is no RX_VALID pulse, and FRAME_ERR<=1.
- **Latency:** DATA_RX and RX_VALID appear 1 CLK after the filtered CS rise is detected.
- **Simultaneous events:** a CS edge and an SCLK edge in the same cycle resolve with the CS edge winning; the SCLK edge is dropped.
- **MISO when not ACTIVE:** SPI_MISO=0.
- **Reset mid-frame:**
  - Aborts immediately; outputs go to reset values.
  - Remaining SCLK edges and the CS rise of the aborted frame are ignored (state IDLE).
  - The next CS fall starts a fresh frame.
- **DATA_TX changes:** changes during ACTIVE have no effect until the next frame.

Test Plan:
- **Mode 0, LSB first, 16-bit frame:** FRAME_BITS=16, mode 0, LSB_FIRST=1, DATA_TX=16'hA5C3; master sends 16'h1234 LSB-first in 16 clocks.
  - DATA_RX=16'h1234, one RX_VALID pulse, FRAME_ERR=0.
  - MISO sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- **Short frame:** same setup, 15 clocks.
  - DATA_RX keeps its previous value, RX_VALID stays 0, FRAME_ERR=1.
  - A following 16-clock frame of 16'hBEEF sets DATA_RX=16'hBEEF and FRAME_ERR=0.
- **Long frame:** 18 clocks.
  - FRAME_ERR=1, DATA_RX unchanged.
  - MISO=0 during clocks 17-18.
- **Mode 3, MSB first:** CPOL=1, CPHA=1, LSB_FIRST=0, DATA_TX=16'h8001; master sends 16'h00FF MSB-first.
  - MISO reads back 16'h8001 when sampled on rising edges.
  - DATA_RX=16'h00FF.
- **Glitch rejection:** FILTER=5; a 4-CLK high pulse on SPI_CLK mid-frame is not counted (frame still completes with 16 real clocks, FRAME_ERR=0). A 7-CLK pulse is counted.
- **Reset mid-frame:** RESET asserted after 8 bits.
  - All outputs are 0 in the same cycle.
  - The remaining 8 clocks and the CS rise produce no RX_VALID and no FRAME_ERR.
  - The next full frame is received correctly.
